qei_velocity: RTL and testbench
===============================

Name: qei_velocity

Overview:
- Velocity estimator directly downstream of a qei position counter.
- Samples the free-running encoder position on a fixed period and computes the signed per-period displacement, handling counter wrap-around.
- Smooths the displacement with a power-of-two moving-average window.
- Outputs raw delta, filtered velocity and a one-cycle valid strobe for the PID/ALU stage that consumes speed.

Parameters:
NBITS, 16, width of the qei position input and of the delta/vel outputs (two's complement)
PERIOD, 48000, sample period in clk cycles (1 kHz at 48 MHz); must be >= 2
AVG_LOG, 2, log2 of the moving-average window length (window = 2**AVG_LOG deltas); range 0..4

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
en  input  1  when low, the period counter holds and no samples are taken
clr  input  1  synchronous soft clear; same effect as rst; rst has priority
pos  input  NBITS  current encoder position from the qei block (unsigned, wraps modulo 2**NBITS)
delta  output  NBITS  signed displacement over the last period
vel  output  NBITS  signed moving-average velocity, in counts per period
valid  output  1  one-cycle pulse when delta/vel update
primed  output  1  high once the averaging window holds 2**AVG_LOG real deltas

Behaviour:
- Reset/clr state:
  - delta=0, vel=0, valid=0, primed=0.
  - Period counter=0, prev=0, running sum=0, all ring-buffer entries=0, write index=0, fill count=0.
  - State=INIT.
- Period counter:
  - Increments each cycle while en=1, counting 0..PERIOD-1 and then wrapping to 0.
  - A sample tick is a cycle with en=1 and count==PERIOD-1.
  - When en=0, the counter holds and no tick occurs.
- States:
  - INIT: on a tick, prev<=pos, go to RUN. No valid pulse and no output change.
  - RUN: on each tick, d = (pos - prev) mod 2**NBITS, interpreted as signed. Then:
    - prev<=pos; delta<=d.
    - sum <= sum + sext(d) - sext(buf[idx]).
    - buf[idx]<=d; idx<=idx+1 mod 2**AVG_LOG.
    - valid<=1 for the next cycle only.
- Sum width is NBITS+AVG_LOG signed. It cannot overflow because it holds at most 2**AVG_LOG NBITS-bit values.
- vel = sum arithmetically shifted right by AVG_LOG (floor rounding toward negative infinity), truncated to NBITS.
  - vel is a registered output that updates in the same cycle as delta.
- Latency: pos is sampled on tick cycle T; delta, vel and valid are visible at T+1. valid is low at all other times.
- primed: the fill count saturates at 2**AVG_LOG; primed goes high together with the valid pulse of the 2**AVG_LOG-th delta after INIT.
  - Before primed, vel ramps up because the empty slots read as zero.
- Wrap-around: modular subtraction gives the correct delta across the 2**NBITS boundary when the true |displacement| < 2**(NBITS-1) per period. Larger displacements alias; no detection is performed.
- AVG_LOG=0: vel==delta on every update; primed goes high on the first RUN tick.
- rst or clr mid-period: all state returns to reset values in the next cycle, and the next tick re-enters INIT.
- Simultaneous clr and tick: the clear wins and no sample is taken.
- delta and vel hold their last values between ticks and while en=0.

Test Plan:
All scenarios use NBITS=16, PERIOD=4, AVG_LOG=2.
1. Assert rst for 3 cycles with pos=0x1234 -> delta=vel=0, valid=primed=0 throughout; first tick after release produces no valid pulse (INIT).
2. Hold pos=100 constant for 6 ticks -> valid pulses once every 4 cycles starting at tick 2; delta=0, vel=0; primed rises at the 5th tick.
3. Ramp pos by +8 per period from 0 -> delta=8 on every update; vel=2,4,6,8 then steady at 8; primed rises with the vel=8 update.
4. Wrap: set pos=0xFFFC at a tick, then 0x0004 at the next tick -> delta=0x0008 (+8), not 0xFFF8-related garbage.
5. Decreasing: from pos=1000 step -3 per period -> first delta=0xFFFD; vel=0xFFFF (-1, floor of -3/4), then -2 (0xFFFE), -3 (0xFFFD, floor of -9/4), -3 steady.
6. Under the ramp of scenario 3:
   - en=0 for 10 cycles mid-period -> no valid pulses, counter resumes from its held count.
   - Then pulse clr -> all outputs return to 0, primed=0, and the next tick is INIT with no valid.

Source files
------------

// File: rtl/qei_velocity_if.sv
// qei_velocity_if: connects a qei position source to the velocity estimator.
//   master: drives en, clr, pos; observes delta, vel, valid, primed
//   slave : the estimator itself
//   en     - sample-period counter enable
//   clr    - synchronous soft clear
//   pos    - free-running encoder position (unsigned, wraps)
//   delta  - signed displacement over the last period
//   vel    - signed moving-average velocity (counts per period)
//   valid  - one-cycle strobe when delta/vel update
//   primed - averaging window filled with real deltas
interface qei_velocity_if #(
  parameter int unsigned NBITS = 16
) ();
  logic             en;
  logic             clr;
  logic [NBITS-1:0] pos;
  logic [NBITS-1:0] delta;
  logic [NBITS-1:0] vel;
  logic             valid;
  logic             primed;

  modport master (
    output en, clr, pos,
    input  delta, vel, valid, primed
  );

  modport slave (
    input  en, clr, pos,
    output delta, vel, valid, primed
  );
endinterface

// File: rtl/qei_velocity.sv
// qei_velocity: samples a wrapping encoder position every PERIOD cycles,
// produces the signed per-period displacement and a 2**AVG_LOG-deep moving
// average of it.
//   clk - system clock
//   rst - synchronous active-high reset
//   qei - qei_velocity_if.slave (en, clr, pos in; delta, vel, valid, primed out)
module qei_velocity #(
  parameter int unsigned NBITS   = 16,
  parameter int unsigned PERIOD  = 48000,
  parameter int unsigned AVG_LOG = 2
) (
  input  logic           clk,
  input  logic           rst,
  qei_velocity_if.slave  qei
);

  localparam int unsigned DEPTH = 1 << AVG_LOG;
  localparam int unsigned CNTW  = $clog2(PERIOD);
  localparam int unsigned IDXW  = (AVG_LOG > 0) ? AVG_LOG : 1;
  localparam int unsigned FILLW = AVG_LOG + 1;
  localparam int unsigned SUMW  = NBITS + AVG_LOG;

  typedef enum logic {INIT, RUN} state_e;

  state_e                  state;
  state_e                  stateNext;
  logic [CNTW-1:0]         cnt;
  logic                    clear;
  logic                    tick;
  logic                    sample;
  logic [NBITS-1:0]        prev;
  logic [NBITS-1:0]        d;
  logic [NBITS-1:0]        ringBuf [DEPTH];
  logic [IDXW-1:0]         idx;
  logic [IDXW-1:0]         idxNext;
  logic [FILLW-1:0]        fill;
  logic [FILLW-1:0]        fillNext;
  logic signed [SUMW-1:0]  sum;
  logic signed [SUMW-1:0]  sumNext;

  assign clear  = rst | qei.clr;
  assign tick   = qei.en & (cnt == CNTW'(PERIOD - 1));
  assign sample = tick & (state == RUN);

  // Modular subtraction; the result is read as two's complement.
  assign d = qei.pos - prev;

  // Add the newest delta, retire the one it overwrites in the ring.
  assign sumNext = sum + SUMW'($signed(d)) - SUMW'($signed(ringBuf[idx]));

  assign idxNext  = (idx == IDXW'(DEPTH - 1)) ? '0 : idx + IDXW'(1);
  assign fillNext = (fill == FILLW'(DEPTH)) ? fill : fill + FILLW'(1);

  // Sample-period counter; holds while en is low.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (qei.en) begin
      cnt <= tick ? '0 : cnt + CNTW'(1);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clear) begin
      state <= INIT;
    end else begin
      state <= stateNext;
    end
  end

  // Next state: the first tick only captures a baseline position.
  always_comb begin
    stateNext = state;
    case (state)
      INIT:    if (tick) stateNext = RUN;
      RUN:     stateNext = RUN;
      default: stateNext = INIT;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (clear) begin
      prev       <= '0;
      sum        <= '0;
      idx        <= '0;
      fill       <= '0;
      qei.delta  <= '0;
      qei.vel    <= '0;
      qei.valid  <= 1'b0;
      qei.primed <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ringBuf[i] <= '0;
      end
    end else begin
      qei.valid <= 1'b0;
      if (tick) begin
        prev <= qei.pos;
      end
      if (sample) begin
        qei.delta    <= d;
        qei.vel      <= NBITS'(sumNext >>> AVG_LOG);
        qei.valid    <= 1'b1;
        sum          <= sumNext;
        ringBuf[idx] <= d;
        idx          <= idxNext;
        fill         <= fillNext;
        if (fillNext == FILLW'(DEPTH)) begin
          qei.primed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_qei_velocity.sv
// tb_qei_velocity: directed scenarios plus randomized stimulus checked every
// cycle against a window-of-deltas reference model.
module tb_qei_velocity;

  localparam int NBITS   = 16;
  localparam int PERIOD  = 4;
  localparam int AVG_LOG = 2;
  localparam int DEPTH   = 4;
  localparam int MASK    = 'hFFFF;

  logic clk = 1'b0;
  logic rst;

  qei_velocity_if #(.NBITS(NBITS)) bus ();

  qei_velocity #(
    .NBITS  (NBITS),
    .PERIOD (PERIOD),
    .AVG_LOG(AVG_LOG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .qei(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: position history reduced to a queue of the last DEPTH deltas.
  int mCnt;
  bit mRun;
  int mPrev;
  int hist[$];
  int mDelta;
  int mVel;
  bit mValid;
  bit mPrimed;
  int mCount;

  function automatic void modelReset();
    mCnt = 0; mRun = 0; mPrev = 0; hist.delete();
    mDelta = 0; mVel = 0; mValid = 0; mPrimed = 0; mCount = 0;
  endfunction

  function automatic void modelTick(input int p);
    int dl;
    int s;
    int q;
    if (!mRun) begin
      mRun  = 1;
      mPrev = p;
    end else begin
      dl = (p - mPrev) & MASK;
      if (dl >= 32768) dl -= 65536;
      hist.push_back(dl);
      if (hist.size() > DEPTH) void'(hist.pop_front());
      s = 0;
      foreach (hist[i]) s += hist[i];
      q = s / DEPTH;
      if (s < 0 && q * DEPTH != s) q--;
      mDelta  = dl & MASK;
      mVel    = q & MASK;
      mValid  = 1;
      mCount++;
      mPrimed = (mCount >= DEPTH);
      mPrev   = p;
    end
  endfunction

  function automatic void modelStep(input bit r, input bit e, input bit c, input int p);
    if (r || c) begin
      modelReset();
    end else begin
      mValid = 0;
      if (e) begin
        if (mCnt == PERIOD - 1) begin
          mCnt = 0;
          modelTick(p);
        end else begin
          mCnt++;
        end
      end
    end
  endfunction

  int velLog[$];

  task automatic cycle(input bit r, input bit e, input bit c, input int p);
    rst     = r;
    bus.en  = e;
    bus.clr = c;
    bus.pos = 16'(p);
    @(posedge clk);
    modelStep(r, e, c, p & MASK);
    #1;
    checkVal("valid",  32'(bus.valid),  32'(mValid));
    checkVal("primed", 32'(bus.primed), 32'(mPrimed));
    checkVal("delta",  32'(bus.delta),  32'(mDelta));
    checkVal("vel",    32'(bus.vel),    32'(mVel));
    if (bus.valid === 1'b1) velLog.push_back(int'(bus.vel));
  endtask

  task automatic period(input int p);
    repeat (PERIOD) cycle(0, 1, 0, p);
  endtask

  task automatic doReset(input int p);
    repeat (3) cycle(1, 1, 0, p);
    velLog.delete();
  endtask

  task automatic checkLog(input string tag, input int exp[$]);
    checkVal({tag, "_count"}, 32'(velLog.size()), 32'(exp.size()));
    foreach (exp[i]) begin
      if (i < velLog.size()) checkVal(tag, 32'(velLog[i]), 32'(exp[i] & MASK));
    end
  endtask

  int rp;
  int sel;
  bit rr, rc, re;

  initial begin
    modelReset();

    // Reset held with a nonzero position, then INIT tick without a pulse.
    doReset('h1234);
    checkVal("rst_delta", 32'(bus.delta), 32'h0);
    period('h1234);
    checkVal("init_no_pulse", 32'(velLog.size()), 32'h0);

    // Constant position.
    doReset(100);
    repeat (7) period(100);
    checkLog("const_vel", '{0, 0, 0, 0, 0, 0});
    checkVal("const_primed", 32'(bus.primed), 32'h1);

    // Ramp +8 per period.
    doReset(0);
    for (int k = 0; k < 7; k++) period(8 * k);
    checkLog("ramp_vel", '{2, 4, 6, 8, 8, 8});

    // Wrap across the top of the position range.
    doReset(0);
    period('hFFFC);
    period('h0004);
    checkVal("wrap_delta", 32'(bus.delta), 32'h8);

    // Decreasing, -3 per period.
    doReset(1000);
    period(1000);
    period(997);
    checkVal("down_delta", 32'(bus.delta), 32'hFFFD);
    for (int k = 2; k < 6; k++) period(1000 - 3 * k);
    checkLog("down_vel", '{-1, -2, -3, -3, -3});

    // Ramp with en dropped mid-period, then clr, then clr coinciding with a tick.
    doReset(0);
    for (int k = 0; k < 4; k++) period(8 * k);
    cycle(0, 1, 0, 32);
    cycle(0, 1, 0, 32);
    velLog.delete();
    repeat (10) cycle(0, 0, 0, 32);
    checkVal("en_low_no_pulse", 32'(velLog.size()), 32'h0);
    cycle(0, 1, 0, 32);
    cycle(0, 1, 0, 32);
    checkVal("resume_pulse", 32'(velLog.size()), 32'h1);
    cycle(0, 1, 1, 40);
    checkVal("clr_vel", 32'(bus.vel), 32'h0);
    checkVal("clr_primed", 32'(bus.primed), 32'h0);
    velLog.delete();
    period(40);
    checkVal("clr_init_no_pulse", 32'(velLog.size()), 32'h0);
    period(48);
    period(56);
    repeat (3) cycle(0, 1, 0, 64);
    cycle(0, 1, 1, 64);
    checkVal("clr_tick_delta", 32'(bus.delta), 32'h0);

    // Randomized: small steps, occasional large jumps, en gaps, clears, resets.
    rp = 0;
    for (int n = 0; n < 800; n++) begin
      sel = int'($urandom_range(0, 19));
      if (sel == 0) rp = int'($urandom_range(0, 65535));
      else          rp = (rp + int'($urandom_range(0, 400)) - 200) & MASK;
      rr = ($urandom_range(0, 299) == 0);
      rc = ($urandom_range(0, 149) == 0);
      re = ($urandom_range(0, 9) != 0);
      cycle(rr, re, rc, rp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
